// File: rtl/tick_div_pkg.sv
// Shared definitions for the programmable tick divider: FSM state encoding
// and the legacy divide-by-256 constant.
package tick_div_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [7:0] LEGACY_DIV = 8'd255;

endpackage

// File: rtl/tick_div_if.sv
// Control/status bundle for tick_div_prog. The square-wave output sq_out is
// present only when TICK_DIV_SQUARE_EN is defined.
interface tick_div_if #(
   parameter int WIDTH = 8
);

   logic             start;
   logic             stop;
   logic             oneshot;
   logic             div_load;
   logic [WIDTH-1:0] div_val;
   logic             tick;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] count;
`ifdef TICK_DIV_SQUARE_EN
   logic             sq_out;

   modport master (
      output start, stop, oneshot, div_load, div_val,
      input  tick, busy, done, count, sq_out
   );

   modport slave (
      input  start, stop, oneshot, div_load, div_val,
      output tick, busy, done, count, sq_out
   );
`else
   modport master (
      output start, stop, oneshot, div_load, div_val,
      input  tick, busy, done, count
   );

   modport slave (
      input  start, stop, oneshot, div_load, div_val,
      output tick, busy, done, count
   );
`endif

endinterface

// File: rtl/tick_div_reload.sv
// Divisor shadow register with a pending flag. A new divisor is handed to the
// counter immediately while it is not running, and only at the terminal-count
// cycle while it is running, so a period in progress is never cut short.
module tick_div_reload
   import tick_div_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             div_load,
   input  logic [WIDTH-1:0] div_val,
   input  logic             in_run,
   input  logic             wrap,
   output logic             upd_valid,
   output logic [WIDTH-1:0] upd_val
);

   logic [WIDTH-1:0] shadow_q, shadow_d;
   logic             pend_q, pend_d;

   // Capture loads (last one wins) and decide when the shadow value is released.
   always_comb begin
      shadow_d  = div_load ? div_val : shadow_q;
      pend_d    = pend_q | div_load;
      upd_valid = 1'b0;
      upd_val   = shadow_d;
      if ((div_load || pend_q) && (!in_run || wrap)) begin
         upd_valid = 1'b1;
         pend_d    = 1'b0;
      end
   end

   // Shadow and pending flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= DEFAULT_DIV;
         pend_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         pend_q   <= pend_d;
      end
   end

endmodule

// File: rtl/tick_div_prog.sv
// Runtime-programmable clock-enable generator: one-cycle tick every
// (divisor+1) clocks, periodic or one-shot, with start/stop control and
// wrap-aligned divisor reload. Defining TICK_DIV_SQUARE_EN adds sq_out, a
// square wave toggling on every tick.
module tick_div_prog
   import tick_div_pkg::*;
#(
   parameter int               WIDTH       = 8,
   parameter logic [WIDTH-1:0] DEFAULT_DIV = {WIDTH{1'b1}},
   parameter bit               AUTOSTART   = 1'b1
) (
   input logic       clk,
   input logic       rst,
   tick_div_if.slave bus
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] div_reg_q, div_reg_d;
   logic             tick_q, tick_d;
   logic             mode_os_q, mode_os_d;
   logic             wrap;
   logic             in_run;
   logic             upd_valid;
   logic [WIDTH-1:0] upd_val;

   assign in_run = (state_q == ST_RUN);

   tick_div_reload #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
   ) u_reload (
      .clk       (clk),
      .rst       (rst),
      .div_load  (bus.div_load),
      .div_val   (bus.div_val),
      .in_run    (in_run),
      .wrap      (wrap),
      .upd_valid (upd_valid),
      .upd_val   (upd_val)
   );

   // Next-state, counter and tick logic; stop beats start, start in RUN restarts.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      tick_d    = 1'b0;
      mode_os_d = mode_os_q;
      wrap      = 1'b0;
      div_reg_d = upd_valid ? upd_val : div_reg_q;
      unique case (state_q)
         ST_IDLE: begin
            count_d = '0;
            if (!bus.stop && bus.start) begin
               state_d   = ST_RUN;
               mode_os_d = bus.oneshot;
            end
         end
         ST_RUN: begin
            if (bus.stop) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (bus.start) begin
               count_d   = '0;
               mode_os_d = bus.oneshot;
            end else if (count_q == div_reg_q) begin
               wrap    = 1'b1;
               tick_d  = 1'b1;
               count_d = '0;
               if (mode_os_q) begin
                  state_d = ST_DONE;
               end
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end
         ST_DONE: begin
            count_d = '0;
            if (bus.stop) begin
               state_d = ST_IDLE;
            end else if (bus.start) begin
               state_d   = ST_RUN;
               mode_os_d = bus.oneshot;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   // State, counter, divisor and tick registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= AUTOSTART ? ST_RUN : ST_IDLE;
         count_q   <= '0;
         div_reg_q <= DEFAULT_DIV;
         tick_q    <= 1'b0;
         mode_os_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         div_reg_q <= div_reg_d;
         tick_q    <= tick_d;
         mode_os_q <= mode_os_d;
      end
   end

   assign bus.tick  = tick_q;
   assign bus.busy  = (state_q == ST_RUN);
   assign bus.done  = (state_q == ST_DONE);
   assign bus.count = count_q;

`ifdef TICK_DIV_SQUARE_EN
   logic sq_q, sq_d;

   // Square wave flips in step with each tick, so it only moves while running.
   always_comb begin
      sq_d = tick_d ? ~sq_q : sq_q;
   end

   // Square wave register.
   always_ff @(posedge clk) begin
      if (rst) begin
         sq_q <= 1'b0;
      end else begin
         sq_q <= sq_d;
      end
   end

   assign bus.sq_out = sq_q;
`endif

endmodule

// File: doc/tick_div_prog.md
Name: tick_div_prog

Overview:
- Parametrised, runtime-programmable clock-enable generator. Generalises the fixed free-running divide-by-256 enable.
- Emits single-cycle `tick` pulses every (divisor+1) clk cycles.
- Supports periodic and one-shot modes, start/stop control, and glitch-free divisor reload.
- Drives game-speed, debounce and LED-scan enables from the system clock.

Parameters:
- WIDTH, 8, counter/divisor width in bits.
- DEFAULT_DIV, 2**WIDTH-1, divisor loaded at reset (255 gives legacy /256).
- AUTOSTART, 1, 1 = enter RUN after reset; 0 = wait in IDLE for start.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; begin counting from 0.
- stop  in  1  pulse; halt and return to IDLE.
- oneshot  in  1  mode, sampled on start: 1 = single tick then DONE, 0 = periodic.
- div_load  in  1  pulse; capture div_val into shadow register.
- div_val  in  WIDTH  new divisor (period = div_val+1 cycles).
- tick  out  1  one-cycle enable pulse, registered.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot complete), held until start/stop/rst.
- count  out  WIDTH  current counter value.

Behaviour:
- Reset (rst high at clk edge):
  - count=0, tick=0, done=0, div_reg=shadow=DEFAULT_DIV, pend=0, mode_os=0.
  - State = RUN if AUTOSTART else IDLE; busy reflects that state.
  - Reset overrides all other inputs in the same cycle. Reset mid-count aborts with no tick.
- States: IDLE, RUN, DONE (2-bit encoding).
  - IDLE: count held at 0, tick=0. start -> RUN, mode_os<=oneshot, count<=0.
  - RUN: if count==div_reg, then tick<=1 next cycle and count<=0; else count<=count+1.
    - Wrap with mode_os=1 -> DONE.
  - DONE: count=0, done=1. start -> RUN; stop -> IDLE.
  - stop in RUN -> IDLE, count<=0, no tick issued even if at terminal count.
- Simultaneous events:
  - stop and start in the same cycle: stop wins.
  - start in RUN restarts count at 0, re-samples oneshot, and suppresses the tick for that cycle.
- Tick latency: tick is registered, asserted in the cycle after count==div_reg.
  - Periodic period = div_reg+1 cycles exactly.
  - First tick after start occurs div_reg+1 cycles after the start edge.
- Divisor reload:
  - div_load writes shadow and sets pend.
  - In IDLE/DONE: div_reg<=div_val immediately and pend cleared.
  - In RUN: div_reg<=shadow only at wrap (the terminal-count cycle), so a period is never truncated.
  - Multiple loads before a wrap: the last one wins.
  - div_load coincident with wrap: the new value applies at that wrap.
- div_val=0: tick every cycle (continuous high) in periodic RUN; one-shot gives one tick.
- Counter arithmetic is modulo 2**WIDTH. No overflow is possible since compare happens at div_reg ≤ 2**WIDTH-1.

Optional Feature:
- Macro TICK_DIV_SQUARE_EN.
- Defined: adds output `sq_out` (1 bit), a registered square wave that toggles on every tick, giving period 2*(div_reg+1).
  - Reset value 0; held in IDLE/DONE.
- Undefined: port and register absent; behaviour otherwise identical.

Decomposition:
- Package tick_div_pkg holds:
  - State enum/constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Helper constant for legacy divisor 8'd255.
- Natural sub-module: tick_div_reload (shadow register + pend logic), instantiated once.
- Counter/FSM stay in the top.

Test Plan:
- Reset, AUTOSTART=1, WIDTH=8, default divisor -> first tick at cycle 256 after rst deassert, then every 256 cycles; count wraps 255->0.
- AUTOSTART=0, div_load div_val=3, start with oneshot=0 -> ticks at cycles 4, 8, 12 after start; busy=1 throughout.
- oneshot=1, div_val=5, start -> exactly one tick 6 cycles after start, then done=1, busy=0, count stays 0 for 20 cycles.
- Periodic with div=9, div_load div_val=2 at count=4 -> current period still 10 cycles, next periods 3 cycles; no short period.
- start and stop together in RUN -> IDLE, no tick; rst asserted at count=7 mid-run -> count=0, tick=0 next cycle, div_reg=255.
- div_val=0 periodic -> tick high every cycle; with TICK_DIV_SQUARE_EN, sq_out toggles each cycle. With div=1, sq_out has period 4.
